cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cache_fill_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_arbiter.sv
// Purpose: shares one 16-bit memory port between I-cache fills, D-cache fills and D-cache write-throughs.
// Latency: grant in an IDLE cycle, memory op the next cycle; fill words reach the cache combinationally from mem_data_out.
// Backpressure: requests are held by the requester and wait while busy; no preemption, writes win ties at grant.
//
// Ports:
//   clk, rst                            - clock, synchronous active-high reset
//   i_miss/i_miss_addr                  - I-cache miss request (held until i_fill_done)
//   d_miss/d_miss_addr                  - D-cache miss request (held until d_fill_done)
//   d_wr_req/d_wr_addr/d_wr_data        - D-cache write-through (held until d_wr_ack)
//   mem_enable/mem_wr/mem_addr/mem_data_in, mem_data_out/mem_data_valid - memory side
//   fill_data/fill_word/i_fill_we/d_fill_we/i_fill_done/d_fill_done/d_wr_ack/busy - cache side
module cache_fill_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_miss,
    input  logic [ADDR_WIDTH-1:0]          i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_WIDTH-1:0]          d_miss_addr,
    input  logic                           d_wr_req,
    input  logic [ADDR_WIDTH-1:0]          d_wr_addr,
    input  logic [15:0]                    d_wr_data,
    output logic                           mem_enable,
    output logic                           mem_wr,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [15:0]                    mem_data_in,
    input  logic [15:0]                    mem_data_out,
    input  logic                           mem_data_valid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_fill_done,
    output logic                           d_fill_done,
    output logic                           d_wr_ack,
    output logic                           busy
);

    localparam int WW = $clog2(BLOCK_WORDS);
    localparam int CW = WW + 1;
    // Byte-offset bits of one block: BLOCK_WORDS words of 2 bytes each.
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(2 * BLOCK_WORDS - 1);
    localparam logic [CW-1:0]         LAST     = CW'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;           // 1 = D-cache owns the fill
    logic                  last_owner_q, last_owner_d; // last miss granted, 1 = D
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]         recv_cnt_q, recv_cnt_d;
    // Completion pulses delayed by one cycle; a requester may still be
    // holding its request in the IDLE cycle right after its done/ack, so that
    // request is masked for exactly that cycle.
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  ack_q, ack_d;

    logic wr_ok, i_ok, d_ok, miss_pick;

    assign wr_ok     = d_wr_req & ~ack_q;
    assign i_ok      = i_miss & ~i_done_q;
    assign d_ok      = d_miss & ~d_done_q;
    // On a tie the requester not granted last time wins.
    assign miss_pick = (i_ok & d_ok) ? ~last_owner_q : d_ok;

    assign busy     = (state_q != S_IDLE);
    assign i_done_d = i_fill_done;
    assign d_done_d = d_fill_done;
    assign ack_d    = d_wr_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            ack_q        <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;

        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        fill_data    = mem_data_out;
        fill_word    = '0;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        d_wr_ack     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_ok) begin
                    state_d     = S_WRITE;
                    addr_d      = {d_wr_addr[ADDR_WIDTH-1:1], 1'b0};
                    wdata_d     = d_wr_data;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end else if (i_ok || d_ok) begin
                    state_d      = S_ISSUE;
                    owner_d      = miss_pick;
                    last_owner_d = miss_pick;
                    addr_d       = (miss_pick ? d_miss_addr : i_miss_addr) & ~OFF_MASK;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                end
            end
            S_WRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q;
                mem_data_in = wdata_q;
                d_wr_ack    = 1'b1;
                state_d     = S_IDLE;
            end
            S_ISSUE: begin
                mem_enable  = 1'b1;
                mem_addr    = addr_q + ADDR_WIDTH'({issue_cnt_q, 1'b0});
                issue_cnt_d = issue_cnt_q + CW'(1);
                if (issue_cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Returned words are counted separately from issues, so data may
        // arrive while addresses are still going out, with any latency.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && mem_data_valid) begin
            fill_word  = recv_cnt_q[WW-1:0];
            i_fill_we  = ~owner_q;
            d_fill_we  = owner_q;
            recv_cnt_d = recv_cnt_q + CW'(1);
            if (recv_cnt_q == LAST) begin
                i_fill_done = ~owner_q;
                d_fill_done = owner_q;
                state_d     = S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_enable, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

    cache_fill_arbiter #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_ack(d_wr_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } mop_t;
    typedef struct { bit d; int word; logic [15:0] data; } fop_t;
    typedef struct { logic [15:0] addr; int t; } pend_t;

    mop_t  mem_exp[$];
    fop_t  fill_exp[$];
    pend_t pend[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_cnt = 0;
    int fill_cnt = 0;
    int fill_start = 0;
    int evt_cnt[3];   // 0: i_fill_done, 1: d_fill_done, 2: d_wr_ack
    int evt_cyc[3];
    int last_t = 0;
    bit rand_gap = 0;
    bit mon_en = 0;
    bit last_owner = 0; // reference model: last miss granted, 1 = D
    bit drop_i = 0, drop_d = 0, drop_w = 0;

    function automatic logic [15:0] memval(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a fill reads the 8 words of the 16-byte block in order
    // and hands them to the owner in order 0..7.
    task automatic push_fill(input bit d, input logic [15:0] a);
        logic [15:0] base;
        base = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            mem_exp.push_back('{1'b0, base + 16'(2 * k), 16'h0});
            fill_exp.push_back('{d, k, memval(base + 16'(2 * k))});
        end
        last_owner = d;
    endtask

    task automatic push_write(input logic [15:0] a, input logic [15:0] dat);
        mem_exp.push_back('{1'b1, {a[15:1], 1'b0}, dat});
    endtask

    task automatic wait_evt(input int idx, input int target, output int at);
        at = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk); #1;
            if (evt_cnt[idx] >= target) begin
                at = evt_cyc[idx];
                return;
            end
        end
        chk("event timeout", 64'(evt_cnt[idx]), 64'(target));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        step(3);
        rst = 1'b0;
        last_owner = 0;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory: returns each read after >=4 cycles, in order; optional random spacing.
    initial begin
        mem_data_valid = 0;
        mem_data_out   = 0;
        forever begin
            pend_t p;
            @(posedge clk); #1;
            mem_data_valid = 0;
            mem_data_out   = 16'($urandom);
            if (pend.size() > 0 && pend[0].t <= cyc) begin
                p = pend.pop_front();
                mem_data_valid = 1;
                mem_data_out   = memval(p.addr);
            end
        end
    end

    // Requesters drop their request the cycle after done/ack.
    initial forever begin
        @(posedge clk); #1;
        if (drop_i) begin i_miss = 0;   drop_i = 0; end
        if (drop_d) begin d_miss = 0;   drop_d = 0; end
        if (drop_w) begin d_wr_req = 0; drop_w = 0; end
    end

    // Monitor / scoreboard
    bit prev_busy = 0;
    initial forever begin
        mop_t m;
        fop_t f;
        int   t;
        @(negedge clk);
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (busy && !prev_busy && mem_enable && !mem_wr) fill_start = cyc;
            prev_busy = busy;

            if (mem_enable) begin
                chk("mem op expected", 64'(mem_exp.size() > 0), 64'd1);
                if (mem_exp.size() > 0) begin
                    m = mem_exp.pop_front();
                    chk("mem op", {mem_wr, mem_addr, mem_data_in}, {m.wr, m.addr, m.data});
                end
                chk("wr ack with write", 64'(d_wr_ack), 64'(mem_wr));
                if (!mem_wr) begin
                    t = cyc + 4;
                    if (rand_gap && t < last_t + 4) t = last_t + 4;
                    if (rand_gap) t = t + $urandom_range(0, 6);
                    last_t = t;
                    pend.push_back('{mem_addr, t});
                end
            end else begin
                chk("idle mem bus", {mem_wr, mem_addr, mem_data_in, d_wr_ack}, 64'd0);
            end

            if (i_fill_we || d_fill_we) begin
                fill_cnt++;
                chk("single fill we", 64'(i_fill_we & d_fill_we), 64'd0);
                chk("fill expected", 64'(fill_exp.size() > 0), 64'd1);
                if (fill_exp.size() > 0) begin
                    f = fill_exp.pop_front();
                    chk("fill word",
                        {d_fill_we, fill_word, fill_data, i_fill_done, d_fill_done},
                        {f.d, 3'(f.word), f.data, !f.d && f.word == 7, f.d && f.word == 7});
                end
            end
            if (i_fill_done || d_fill_done)
                chk("done implies we", {i_fill_done & ~i_fill_we, d_fill_done & ~d_fill_we}, 64'd0);

            if (i_fill_done) begin evt_cnt[0]++; evt_cyc[0] = cyc; drop_i = 1; end
            if (d_fill_done) begin evt_cnt[1]++; evt_cyc[1] = cyc; drop_d = 1; end
            if (d_wr_ack)    begin evt_cnt[2]++; evt_cyc[2] = cyc; drop_w = 1; end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_d, c_i, c_w, b0, f0, d0, n;
        logic [15:0] a1, a2, wd;
        bit w;
        int kind;
        for (int k = 0; k < 3; k++) begin evt_cnt[k] = 0; evt_cyc[k] = 0; end
        i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        rst = 1;
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        @(posedge clk); #1;
        mon_en = 1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("reset outputs", {busy, mem_enable, mem_wr, mem_addr, mem_data_in, i_fill_we, d_fill_we,
                              i_fill_done, d_fill_done, d_wr_ack}, 64'd0);

        // Tie from reset: D first, then I granted the cycle after D done + 1
        step(1);
        push_fill(1, 16'h2204);
        push_fill(0, 16'h3318);
        d_miss_addr = 16'h2204; i_miss_addr = 16'h3318;
        d_miss = 1; i_miss = 1;
        wait_evt(1, evt_cnt[1] + 1, c_d);
        wait_evt(0, evt_cnt[0] + 1, c_i);
        chk("tie I start", 64'(fill_start), 64'(c_d + 2));

        // Single I fill, 4-cycle memory: done 11 cycles after first issue
        step(2);
        b0 = busy_cnt;
        push_fill(0, 16'h1236);
        i_miss_addr = 16'h1236; i_miss = 1;
        wait_evt(0, evt_cnt[0] + 1, c_i);
        chk("I done timing", 64'(c_i - fill_start), 64'd11);
        @(negedge clk);
        chk("idle after fill", 64'(busy), 64'd0);
        chk("fill busy cycles", 64'(busy_cnt - b0), 64'd12);

        // Write-through
        step(2);
        b0 = busy_cnt;
        push_write(16'h0041, 16'hBEEF);
        d_wr_addr = 16'h0041; d_wr_data = 16'hBEEF; d_wr_req = 1;
        wait_evt(2, evt_cnt[2] + 1, c_w);
        step(2);
        chk("write busy cycles", 64'(busy_cnt - b0), 64'd1);

        // Write raised during an I fill waits for it
        push_fill(0, 16'h4A5C);
        i_miss_addr = 16'h4A5C; i_miss = 1;
        step(4);
        push_write(16'h7777, 16'h1234);
        d_wr_addr = 16'h7777; d_wr_data = 16'h1234; d_wr_req = 1;
        wait_evt(0, evt_cnt[0] + 1, c_i);
        wait_evt(2, evt_cnt[2] + 1, c_w);
        chk("write after fill", 64'(c_w), 64'(c_i + 2));

        // Reset at the 3rd fill_we of a D fill
        step(2);
        push_fill(1, 16'h5100);
        d_miss_addr = 16'h5100; d_miss = 1;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clk);
            if (d_fill_we) n++;
        end
        chk("third fill reached", 64'(n), 64'd3);
        #1;
        rst = 1;
        d0 = evt_cnt[1];
        f0 = fill_cnt;
        @(posedge clk); #1;
        rst = 0; d_miss = 0;
        mem_exp.delete(); fill_exp.delete();
        last_owner = 0;
        @(negedge clk);
        chk("outputs after reset", {busy, mem_enable, mem_wr, mem_addr, mem_data_in, i_fill_we, d_fill_we,
                                    i_fill_done, d_fill_done, d_wr_ack}, 64'd0);
        repeat (20) @(negedge clk);
        chk("late valids ignored", 64'(fill_cnt - f0), 64'd1 - 64'd1 + 64'(fill_cnt - fill_cnt));
        chk("no done after reset", 64'(evt_cnt[1]), 64'(d0));
        step(1);

        // Random traffic with random memory gaps
        rand_gap = 1;
        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 4);
            a1 = 16'($urandom); a2 = 16'($urandom); wd = 16'($urandom);
            case (kind)
                0: begin
                    push_fill(0, a1);
                    i_miss_addr = a1; i_miss = 1;
                    wait_evt(0, evt_cnt[0] + 1, c_i);
                end
                1: begin
                    push_fill(1, a1);
                    d_miss_addr = a1; d_miss = 1;
                    wait_evt(1, evt_cnt[1] + 1, c_d);
                end
                2: begin
                    push_write(a1, wd);
                    d_wr_addr = a1; d_wr_data = wd; d_wr_req = 1;
                    wait_evt(2, evt_cnt[2] + 1, c_w);
                end
                3: begin
                    w = ~last_owner;
                    push_fill(w, w ? a1 : a2);
                    push_fill(~w, w ? a2 : a1);
                    d_miss_addr = a1; i_miss_addr = a2;
                    d_miss = 1; i_miss = 1;
                    b0 = evt_cnt[0] + 1;
                    f0 = evt_cnt[1] + 1;
                    wait_evt(w ? 1 : 0, w ? f0 : b0, c_d);
                    wait_evt(w ? 0 : 1, w ? b0 : f0, c_i);
                end
                default: begin
                    push_write(a1, wd);
                    push_fill(0, a2);
                    d_wr_addr = a1; d_wr_data = wd; i_miss_addr = a2;
                    d_wr_req = 1; i_miss = 1;
                    wait_evt(2, evt_cnt[2] + 1, c_w);
                    wait_evt(0, evt_cnt[0] + 1, c_i);
                end
            endcase
            step(2);
        end

        step(4);
        chk("mem ops left", 64'(mem_exp.size()), 64'd0);
        chk("fills left", 64'(fill_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
